// File: rtl/mac_learn_table.sv
// mac_learn_table: per-port source-MAC learning tables with programmable
// aging and a one-cycle destination lookup returning an egress port mask.
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   learn_valid/mac     per-port learn request (port p at [p*MAC_W +: MAC_W])
//   learn_ready         per-port accept (low while a learn is in stage 1 or
//                       while flush is high)
//   age_limit           expiry age, 0 disables aging expiry
//   flush               invalidate every entry, drop in-flight learns
//   lookup_valid/mac    destination lookup request
//   lookup_out_valid    one-cycle result strobe with lookup_hit/lookup_mask
//   entry_count         registered valid-entry popcount per port
module mac_learn_table #(
  parameter int unsigned PORT_NUMBER = 4,
  parameter int unsigned ENTRIES     = 8,
  parameter int unsigned MAC_W       = 48,
  parameter int unsigned AGE_W       = 8,
  parameter int unsigned TICK_DIV    = 1000000
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [PORT_NUMBER-1:0]                    learn_valid,
  input  logic [PORT_NUMBER*MAC_W-1:0]              learn_mac,
  output logic [PORT_NUMBER-1:0]                    learn_ready,
  input  logic [AGE_W-1:0]                          age_limit,
  input  logic                                      flush,
  input  logic                                      lookup_valid,
  input  logic [MAC_W-1:0]                          lookup_mac,
  output logic                                      lookup_out_valid,
  output logic                                      lookup_hit,
  output logic [PORT_NUMBER-1:0]                    lookup_mask,
  output logic [PORT_NUMBER*$clog2(ENTRIES+1)-1:0]  entry_count
);

  localparam int unsigned CNT_W  = $clog2(ENTRIES + 1);
  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned IG_BIT = 40;

  // Table storage
  logic [ENTRIES-1:0] ent_valid [PORT_NUMBER];
  logic [MAC_W-1:0]   ent_mac   [PORT_NUMBER][ENTRIES];
  logic [AGE_W-1:0]   ent_age   [PORT_NUMBER][ENTRIES];

  logic [ENTRIES-1:0] nxt_valid [PORT_NUMBER];
  logic [MAC_W-1:0]   nxt_mac   [PORT_NUMBER][ENTRIES];
  logic [AGE_W-1:0]   nxt_age   [PORT_NUMBER][ENTRIES];

  // Learn pipeline stage 1
  logic [PORT_NUMBER-1:0] s1_valid;
  logic [MAC_W-1:0]       s1_mac [PORT_NUMBER];
  logic [ENTRIES-1:0]     s1_hit [PORT_NUMBER];

  logic [PORT_NUMBER-1:0] accept;
  logic [ENTRIES-1:0]     cmp     [PORT_NUMBER];
  logic [ENTRIES-1:0]     refresh [PORT_NUMBER];
  logic [PORT_NUMBER-1:0] lk_match;
  logic [CNT_W-1:0]       cnt_c   [PORT_NUMBER];

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  // Age tick generator, keeps running through flush
  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TICK_W'(1);
  end

  // One learn in flight per port; flush and reset block acceptance
  assign learn_ready = ~s1_valid & {PORT_NUMBER{~(rst | flush)}};
  assign accept      = learn_valid & learn_ready;

  // Stage-1 compare of incoming MAC against valid entries
  always_comb begin
    for (int p = 0; p < PORT_NUMBER; p++) begin
      cmp[p] = '0;
      for (int i = 0; i < ENTRIES; i++)
        cmp[p][i] = ent_valid[p][i] && (ent_mac[p][i] == learn_mac[p*MAC_W +: MAC_W]);
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < PORT_NUMBER; p++) begin
      if (rst || flush) s1_valid[p] <= 1'b0;
      else              s1_valid[p] <= accept[p];
      if (accept[p]) begin
        s1_mac[p] <= learn_mac[p*MAC_W +: MAC_W];
        s1_hit[p] <= cmp[p];
      end
    end
  end

  // A hit only counts if that entry did not age out since stage 1
  always_comb begin
    for (int p = 0; p < PORT_NUMBER; p++)
      refresh[p] = s1_hit[p] & ent_valid[p];
  end

  // Next table state: age tick first, then stage-2 refresh/insert on top
  always_comb begin
    for (int p = 0; p < PORT_NUMBER; p++) begin
      nxt_valid[p] = ent_valid[p];
      for (int i = 0; i < ENTRIES; i++) begin
        nxt_mac[p][i] = ent_mac[p][i];
        nxt_age[p][i] = ent_age[p][i];
      end
    end
    for (int p = 0; p < PORT_NUMBER; p++) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (tick && ent_valid[p][i]) begin
          nxt_age[p][i] = (&ent_age[p][i]) ? ent_age[p][i] : ent_age[p][i] + AGE_W'(1);
          if ((age_limit != '0) && (nxt_age[p][i] >= age_limit))
            nxt_valid[p][i] = 1'b0;
        end
      end
      if (s1_valid[p] && !s1_mac[p][IG_BIT]) begin
        if (|refresh[p]) begin
          for (int i = 0; i < ENTRIES; i++) begin
            if (refresh[p][i]) begin
              nxt_valid[p][i] = 1'b1;
              nxt_age[p][i]   = '0;
            end
          end
        end else begin
          // Descending so each slot takes the already-aged value below it
          for (int i = ENTRIES - 1; i > 0; i--) begin
            nxt_valid[p][i] = nxt_valid[p][i-1];
            nxt_mac[p][i]   = nxt_mac[p][i-1];
            nxt_age[p][i]   = nxt_age[p][i-1];
          end
          nxt_valid[p][0] = 1'b1;
          nxt_mac[p][0]   = s1_mac[p];
          nxt_age[p][0]   = '0;
        end
      end
    end
  end

  // Table state register
  always_ff @(posedge clk) begin
    for (int p = 0; p < PORT_NUMBER; p++) begin
      if (rst) begin
        ent_valid[p] <= '0;
        for (int i = 0; i < ENTRIES; i++) ent_age[p][i] <= '0;
      end else if (flush) begin
        ent_valid[p] <= '0;
      end else begin
        ent_valid[p] <= nxt_valid[p];
        for (int i = 0; i < ENTRIES; i++) begin
          ent_mac[p][i] <= nxt_mac[p][i];
          ent_age[p][i] <= nxt_age[p][i];
        end
      end
    end
  end

  // Lookup match against the current (pre-update) table, plus popcounts
  always_comb begin
    for (int p = 0; p < PORT_NUMBER; p++) begin
      lk_match[p] = 1'b0;
      cnt_c[p]    = '0;
      for (int i = 0; i < ENTRIES; i++) begin
        if (ent_valid[p][i] && (ent_mac[p][i] == lookup_mac)) lk_match[p] = 1'b1;
        cnt_c[p] = cnt_c[p] + CNT_W'(ent_valid[p][i]);
      end
    end
  end

  // Registered lookup result; group destinations and misses flood
  always_ff @(posedge clk) begin
    if (rst) begin
      lookup_out_valid <= 1'b0;
      lookup_hit       <= 1'b0;
      lookup_mask      <= '0;
    end else begin
      lookup_out_valid <= lookup_valid;
      if (lookup_valid) begin
        if (lookup_mac[IG_BIT] || (lk_match == '0)) begin
          lookup_hit  <= 1'b0;
          lookup_mask <= '1;
        end else begin
          lookup_hit  <= 1'b1;
          lookup_mask <= lk_match;
        end
      end
    end
  end

  // Registered entry counts
  always_ff @(posedge clk) begin
    for (int p = 0; p < PORT_NUMBER; p++) begin
      if (rst) entry_count[p*CNT_W +: CNT_W] <= '0;
      else     entry_count[p*CNT_W +: CNT_W] <= cnt_c[p];
    end
  end

endmodule

// File: tb/tb_mac_learn_table.sv
// tb_mac_learn_table: directed scoreboard bench for mac_learn_table.
// Lookup expectations are queued at issue time and popped by a monitor
// whenever lookup_out_valid is seen; other outputs are checked in-line.
module tb_mac_learn_table;

  localparam int P  = 4;
  localparam int E  = 8;
  localparam int MW = 48;
  localparam int AW = 8;
  localparam int TD = 4;
  localparam int CW = $clog2(E + 1);

  logic              clk;
  logic              rst;
  logic [P-1:0]      learn_valid;
  logic [P*MW-1:0]   learn_mac;
  logic [P-1:0]      learn_ready;
  logic [AW-1:0]     age_limit;
  logic              flush;
  logic              lookup_valid;
  logic [MW-1:0]     lookup_mac;
  logic              lookup_out_valid;
  logic              lookup_hit;
  logic [P-1:0]      lookup_mask;
  logic [P*CW-1:0]   entry_count;

  mac_learn_table #(
    .PORT_NUMBER(P), .ENTRIES(E), .MAC_W(MW), .AGE_W(AW), .TICK_DIV(TD)
  ) dut (
    .clk(clk), .rst(rst),
    .learn_valid(learn_valid), .learn_mac(learn_mac), .learn_ready(learn_ready),
    .age_limit(age_limit), .flush(flush),
    .lookup_valid(lookup_valid), .lookup_mac(lookup_mac),
    .lookup_out_valid(lookup_out_valid), .lookup_hit(lookup_hit),
    .lookup_mask(lookup_mask), .entry_count(entry_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         hit;
    logic [P-1:0] mask;
    logic [15:0]  id;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   lk_id = 0;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_count(input int p, input logic [CW-1:0] exp);
    logic [CW-1:0] act;
    act = entry_count[p*CW +: CW];
    check($sformatf("entry_count[%0d]", p), 32'(act), 32'(exp));
  endtask

  task automatic learn(input int p, input logic [MW-1:0] mac);
    int guard;
    guard = 0;
    while (learn_ready[p] !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    if (guard >= 20) begin
      n_cmp++;
      n_err++;
      $display("FAIL learn_ready timeout port %0d: got 0 expected 1", p);
    end
    learn_valid[p] = 1'b1;
    learn_mac[p*MW +: MW] = mac;
    step();
    learn_valid[p] = 1'b0;
  endtask

  task automatic lookup(input logic [MW-1:0] mac, input logic hit, input logic [P-1:0] mask);
    exp_t e;
    e.hit  = hit;
    e.mask = mask;
    e.id   = 16'(lk_id);
    lk_id++;
    exp_q.push_back(e);
    lookup_valid = 1'b1;
    lookup_mac   = mac;
    step();
    lookup_valid = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (lookup_out_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL lookup unexpected result: got hit=%b mask=%b expected no result",
                 lookup_hit, lookup_mask);
      end else begin
        mon_e = exp_q.pop_front();
        if (lookup_hit !== mon_e.hit || lookup_mask !== mon_e.mask) begin
          n_err++;
          $display("FAIL lookup #%0d: got hit=%b mask=%b expected hit=%b mask=%b",
                   mon_e.id, lookup_hit, lookup_mask, mon_e.hit, mon_e.mask);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [MW-1:0] m [1:9];
    rst          = 1'b1;
    learn_valid  = '0;
    learn_mac    = '0;
    age_limit    = '0;
    flush        = 1'b0;
    lookup_valid = 1'b1;   // held high during reset: no result may appear
    lookup_mac   = 48'h020000000001;
    for (int k = 1; k <= 9; k++) m[k] = 48'h020000000100 + MW'(k);

    // Reset state
    step(3);
    @(negedge clk);
    check("reset learn_ready", 32'(learn_ready), 32'h0);
    check("reset lookup_out_valid", 32'(lookup_out_valid), 32'h0);
    check("reset lookup_hit", 32'(lookup_hit), 32'h0);
    check("reset lookup_mask", 32'(lookup_mask), 32'h0);
    check("reset entry_count", 32'(entry_count), 32'h0);
    step();
    rst          = 1'b0;
    lookup_valid = 1'b0;
    @(negedge clk);
    check("learn_ready after reset", 32'(learn_ready), 32'hF);
    step();
    lookup(48'h020000000001, 1'b0, 4'b1111);
    check_count(0, 0);

    // Learn then lookup: one cycle later floods, two cycles later hits
    learn(2, 48'h0200000000AA);
    lookup(48'h0200000000AA, 1'b0, 4'b1111);
    lookup(48'h0200000000AA, 1'b1, 4'b0100);

    // Eviction on port 0
    for (int k = 1; k <= 9; k++) learn(0, m[k]);
    step(2);
    lookup(m[1], 1'b0, 4'b1111);
    for (int k = 2; k <= 9; k++) lookup(m[k], 1'b1, 4'b0001);
    check_count(0, 8);
    check_count(2, 1);
    learn(0, m[2]);
    step(3);
    check_count(0, 8);
    lookup(m[9], 1'b1, 4'b0001);
    lookup(m[2], 1'b1, 4'b0001);
    lookup(m[1], 1'b0, 4'b1111);

    // Group MACs are accepted and discarded
    learn(1, 48'hFFFFFFFFFFFF);
    learn(1, 48'h01005E000001);
    check("group accepted (ready low)", 32'(learn_ready[1]), 32'h0);
    step(3);
    check_count(1, 0);
    lookup(48'h01005E000001, 1'b0, 4'b1111);

    // Aging, limit 3: unrefreshed entry expires
    flush = 1'b1;
    step();
    flush     = 1'b0;
    age_limit = 8'd3;
    step(2);
    check_count(0, 0);
    learn(3, 48'h020000000033);
    step(3);
    lookup(48'h020000000033, 1'b1, 4'b1000);
    step(16);
    lookup(48'h020000000033, 1'b0, 4'b1111);
    check_count(3, 0);

    // Refresh every 8 cycles (2 ticks) keeps the entry alive
    learn(3, 48'h020000000044);
    repeat (5) begin
      step(7);
      learn(3, 48'h020000000044);
    end
    lookup(48'h020000000044, 1'b1, 4'b1000);

    // Aging disabled
    flush = 1'b1;
    step();
    flush     = 1'b0;
    age_limit = 8'd0;
    learn(3, 48'h020000000055);
    step(40);
    lookup(48'h020000000055, 1'b1, 4'b1000);
    check_count(3, 1);

    // Flush in the commit cycle of a stage-2 miss
    learn(0, 48'h020000000066);
    flush = 1'b1;
    @(negedge clk);
    check("learn_ready during flush", 32'(learn_ready), 32'h0);
    step();
    flush = 1'b0;
    @(negedge clk);
    check("learn_ready after flush", 32'(learn_ready), 32'hF);
    step(2);
    lookup(48'h020000000066, 1'b0, 4'b1111);
    lookup(48'h020000000055, 1'b0, 4'b1111);
    step(2);
    check("entry_count after flush", 32'(entry_count), 32'h0);

    step(3);
    check("scoreboard drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mac_learn_table.md
# mac_learn_table

Parametrised per-port MAC learning table for the GMII switch core. It takes already clock-domain-converted source-MAC learn requests from every ingress port and keeps a small table per port. Entries are aged out on a programmable timer, and a one-cycle lookup port returns the egress port mask for a destination MAC. It replaces the fixed-depth, non-aging table writer and drives the forwarding decision logic in the `clk` domain.

## Interface
- `PORT_NUMBER`, 4, number of switch ports, each with its own table
- `ENTRIES`, 8, table depth per port; must be ≥2
- `MAC_W`, 48, MAC address width
- `AGE_W`, 8, width of the per-entry age counter
- `TICK_DIV`, 1000000, clk cycles per age tick; must be ≥2

- `clk`, in, 1, core clock; all logic is in this domain
- `rst`, in, 1, synchronous, active-high reset
- `learn_valid`, in, PORT_NUMBER, learn request per port
- `learn_mac`, in, PORT_NUMBER*MAC_W, source MAC per port; port p occupies bits [p*MAC_W +: MAC_W]
- `learn_ready`, out, PORT_NUMBER, port may accept a request this cycle
- `age_limit`, in, AGE_W, age at which entries expire; 0 disables aging
- `flush`, in, 1, invalidate all entries of all ports
- `lookup_valid`, in, 1, lookup request
- `lookup_mac`, in, MAC_W, destination MAC to resolve
- `lookup_out_valid`, out, 1, lookup result valid
- `lookup_hit`, out, 1, at least one port table matched
- `lookup_mask`, out, PORT_NUMBER, egress port mask
- `entry_count`, out, PORT_NUMBER*$clog2(ENTRIES+1), number of valid entries per port

## Operation
- Each table entry holds {valid, mac[MAC_W], age[AGE_W]}. Ports are fully independent, so there is no cross-port arbitration.
- **Learn pipeline, per port**:
  - A request is accepted when `learn_valid[p] & learn_ready[p]`. Stage 1 registers the MAC and a compare vector of the valid entries against it.
  - Stage 2 applies the update:
    - **Hit:** clear that entry's age to 0 (refresh). Entry order is unchanged.
    - **Miss:** insert at index 0 with age 0 and shift entries i→i+1. Entry ENTRIES-1 is dropped.
    - **Group MAC:** if bit `mac[40]` (I/G bit) is set, including broadcast, the request is accepted and discarded, with no table change.
- **Aging**:
  - A free-running tick counter runs 0..TICK_DIV-1 and produces a tick on wrap.
  - On each tick, every valid entry's age increments, saturating at all-ones.
  - When `age_limit` ≠ 0, any valid entry with age ≥ `age_limit` after the increment is invalidated in the same update.
- **Priority within one cycle**: `flush` > stage-2 update > age tick.
  - A refreshed or inserted entry gets age 0 even on a tick cycle. All other entries still age on that cycle.
  - `flush` clears every valid bit and discards any stage-1/stage-2 operation in flight. The tick counter keeps running.
- **Lookup**:
  - Samples the table state of the request cycle, before any update committing in that same cycle.
  - `lookup_mask[p]` = 1 if port p holds a valid matching entry.
  - If there is no match, or `lookup_mac[40]` = 1: `lookup_hit` = 0 and `lookup_mask` = all ones (flood).
- `entry_count[p]` is the popcount of port p's valid bits, registered.

## Timing
- **Reset**: all entries invalid, ages 0, tick counter 0, stage valids 0. Outputs during reset:
  - `learn_ready` = 0
  - `lookup_out_valid` = 0, `lookup_hit` = 0, `lookup_mask` = 0
  - `entry_count` = 0
- `learn_ready[p]` = 1 from the first cycle after `rst` deasserts.
- **Learn latency**:
  - Accepted at cycle T, stage 1 at T+1, table updated at the T+2 edge. A lookup sampled at T+2 sees the update.
  - `learn_ready[p]` is 0 in cycle T+1, which stops back-to-back same-MAC hazards. Maximum rate is one learn per port every 2 cycles.
  - `learn_ready[p]` is also 0 in any cycle where `flush` is 1.
- **Lookup latency**: `lookup_valid` at T gives `lookup_out_valid`/`lookup_hit`/`lookup_mask` at T+1, valid for one cycle only.
  - Lookups are accepted every cycle.
  - When `lookup_valid` = 0, `lookup_out_valid` = 0 and `lookup_mask`/`lookup_hit` hold their last values.
- `entry_count` lags the table by 1 cycle.
- `rst` in mid-operation aborts everything on the next edge.

## Test plan
- **Reset state**: after reset, `lookup_mac` = 02:00:00:00:00:01 → at T+1 `lookup_hit` = 0, mask = 4'b1111; `entry_count` all 0.
- **Learn then lookup**:
  - Port 2 learns 02:00:00:00:00:AA.
  - A lookup issued 2 cycles later → `lookup_hit` = 1, mask = 4'b0100.
  - A lookup issued 1 cycle later → mask = 4'b1111.
- **Eviction**: port 0 learns 9 distinct unicast MACs (ENTRIES = 8) → the first MAC misses, the other 8 hit, and `entry_count[0]` = 8. Re-learning the 2nd MAC is a hit and the count stays 8.
- **Group MAC**: port 1 learns FF:FF:FF:FF:FF:FF and 01:00:5E:00:00:01 → both accepted, `entry_count[1]` stays 0, and a lookup floods.
- **Aging** (TICK_DIV = 4, `age_limit` = 3):
  - An entry learned with no refresh is gone after the 3rd tick.
  - An entry refreshed every 2 ticks never expires.
  - With `age_limit` = 0, the entry never expires.
- **Flush race**: `flush` is asserted in the cycle a stage-2 miss would commit → the table is empty afterwards, and `learn_ready` is 0 during the flush cycle.
